// File: rtl/keccak_rho_pi_chi.sv
// Keccak-f[1600] rho, pi and chi step mappings on a full 1600-bit state,
// followed by a single output register with a valid flag (1-cycle latency).
module keccak_rho_pi_chi #(
   parameter int LANE_W = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [25*LANE_W-1:0]  state_in,
   output logic                  out_valid,
   output logic [25*LANE_W-1:0]  state_out
);

   localparam int STATE_W = 25 * LANE_W;

   // Rho offsets, indexed by lane number 5*y+x.
   localparam int unsigned RHO [25] = '{
       0,  1, 62, 28, 27,
      36, 44,  6, 55, 20,
       3, 10, 43, 25, 39,
      41, 45, 15, 21,  8,
      18,  2, 61, 56, 14
   };

   function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v,
                                              input int unsigned        r);
      rotl = (v << r) | (v >> (LANE_W - r));
   endfunction

   logic [LANE_W-1:0]  a_lane [25];
   logic [LANE_W-1:0]  b_lane [25];
   logic [LANE_W-1:0]  p_lane [25];
   logic [LANE_W-1:0]  c_lane [25];
   logic [STATE_W-1:0] state_d;
   logic [STATE_W-1:0] state_q;
   logic               valid_d;
   logic               valid_q;

   for (genvar y = 0; y < 5; y++) begin : g_row
      for (genvar x = 0; x < 5; x++) begin : g_col
         assign a_lane[5*y+x] = state_in[LANE_W*(5*y+x) +: LANE_W];
         assign b_lane[5*y+x] = rotl(a_lane[5*y+x], RHO[5*y+x]);
         // Pi: P[x][y] takes B[(x+3y) mod 5][x], i.e. lane 5*x + (x+3y) mod 5.
         assign p_lane[5*y+x] = b_lane[5*x + ((x + 3*y) % 5)];
         assign c_lane[5*y+x] = p_lane[5*y+x]
                              ^ (~p_lane[5*y + ((x + 1) % 5)] & p_lane[5*y + ((x + 2) % 5)]);
         assign state_d[LANE_W*(5*y+x) +: LANE_W] = c_lane[5*y+x];
      end
   end

   assign valid_d = in_valid;

   // Output register loads every cycle; out_valid qualifies the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
      end
   end

   assign state_out = state_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_keccak_rho_pi_chi.sv
// Bench for keccak_rho_pi_chi: directed vectors, random vectors against a
// bit-level rho/pi/chi reference model, and asynchronous reset behaviour.
module tb_keccak_rho_pi_chi;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [1599:0] state_in;
   logic          out_valid;
   logic [1599:0] state_out;

   int total = 0;
   int bad   = 0;

   keccak_rho_pi_chi #(.LANE_W(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .state_in  (state_in),
      .out_valid (out_valid),
      .state_out (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rho offsets as listed in the algorithm description: RHO_T[x][y].
   int RHO_T [5][5] = '{
      '{ 0, 36,  3, 41, 18},
      '{ 1, 44, 10, 45,  2},
      '{62,  6, 43, 15, 61},
      '{28, 55, 25, 21, 56},
      '{27, 20, 39,  8, 14}
   };

   function automatic logic [1599:0] ref_rpc(input logic [1599:0] a);
      logic          b [5][5][64];
      logic          p [5][5][64];
      logic [1599:0] c;
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            for (int z = 0; z < 64; z++)
               b[x][y][z] = a[64*(5*y+x) + ((z - RHO_T[x][y] + 64) % 64)];
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            for (int z = 0; z < 64; z++)
               p[x][y][z] = b[(x + 3*y) % 5][x][z];
      c = '0;
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            for (int z = 0; z < 64; z++)
               c[64*(5*y+x) + z] = p[x][y][z] ^ (~p[(x+1)%5][y][z] & p[(x+2)%5][y][z]);
      return c;
   endfunction

   function automatic logic [1599:0] rand_state();
      logic [1599:0] s;
      for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
      return s;
   endfunction

   task automatic check_st(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s state_out obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic check_v(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s out_valid obs=%b exp=%b", tag, obs, exp);
      end
   endtask

   // Apply one vector, clock it through, and sample 1 ns after the edge.
   task automatic step(input logic [1599:0] vec, input logic vld);
      state_in = vec;
      in_valid = vld;
      @(posedge clk);
      #1;
   endtask

   logic [1599:0] ones, e_bit0, e_bit64, v_bit64, v, prev;
   logic          vld;

   initial begin
      ones    = '1;
      e_bit0  = '0; e_bit0[0] = 1'b1; e_bit0[192] = 1'b1;
      e_bit64 = '0; e_bit64[641] = 1'b1; e_bit64[833] = 1'b1;
      v_bit64 = '0; v_bit64[64] = 1'b1;

      // Reset held with active inputs.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      state_in = ones;
      repeat (3) @(posedge clk);
      #1;
      check_st("rst_hold", state_out, '0);
      check_v ("rst_hold", out_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_v ("rst_release", out_valid, 1'b1);
      check_st("rst_release", state_out, ones);

      // Directed vectors streamed back-to-back.
      step('0, 1'b1);
      check_st("zero", state_out, '0);
      check_v ("zero", out_valid, 1'b1);
      step(ones, 1'b1);
      check_st("ones", state_out, ones);
      check_v ("ones", out_valid, 1'b1);
      step(1600'd1, 1'b1);
      check_st("bit0", state_out, e_bit0);
      check_v ("bit0", out_valid, 1'b1);
      step(v_bit64, 1'b1);
      check_st("bit64", state_out, e_bit64);
      check_v ("bit64", out_valid, 1'b1);

      // Data is loaded even when in_valid is low.
      step(v_bit64, 1'b0);
      check_st("noval", state_out, e_bit64);
      check_v ("noval", out_valid, 1'b0);

      // Random vectors against the reference model.
      for (int i = 0; i < 30; i++) begin
         v   = rand_state();
         vld = 1'($urandom_range(0, 3) != 0);
         step(v, vld);
         check_st("rand", state_out, ref_rpc(v));
         check_v ("rand", out_valid, vld);
      end

      // Mid-stream asynchronous reset pulse.
      v = rand_state();
      step(v, 1'b1);
      check_st("pre_rst", state_out, ref_rpc(v));
      check_v ("pre_rst", out_valid, 1'b1);
      state_in = rand_state();
      #1 rst_n = 1'b0;
      #1;
      check_st("mid_rst", state_out, '0);
      check_v ("mid_rst", out_valid, 1'b0);
      #2 rst_n = 1'b1;
      step(ones, 1'b0);
      check_v ("post_rst", out_valid, 1'b0);
      check_st("post_rst", state_out, ones);
      prev = rand_state();
      step(prev, 1'b1);
      check_v ("resume", out_valid, 1'b1);
      check_st("resume", state_out, ref_rpc(prev));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
